// File: rtl/cpu_pkg.sv
// Shared decode definitions for the fetch/decode controller: opcodes,
// instruction field positions, the hazard FSM states and field helpers.
package cpu_pkg;

    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_CALL = 6'h03;
    localparam logic [5:0] OP_RET  = 6'h04;
    localparam logic [5:0] OP_JZ   = 6'h05;
    localparam logic [5:0] OP_LD   = 6'h23;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic logic [5:0] get_op(input logic [31:0] word);
        return word[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] get_rs(input logic [31:0] word);
        return word[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] get_rt(input logic [31:0] word);
        return word[RT_HI:RT_LO];
    endfunction

    function automatic logic [15:0] get_imm(input logic [31:0] word);
        return word[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address stack for CALL/RET. Overflowing pushes are dropped and
// underflowing pops read 0; either event sets a sticky error flag.
module return_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_dec;
    logic              full;
    logic              empty;

    assign full    = (ptr == PTR_W'(DEPTH));
    assign empty   = (ptr == '0);
    assign ptr_dec = ptr - 1'b1;
    assign top     = empty ? '0 : mem[ptr_dec[IDX_W-1:0]];

    // ptr counts occupied entries, so it ranges over 0..DEPTH inclusive
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            err <= 1'b0;
        end else if (push) begin
            if (full) begin
                err <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                ptr <= ptr_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[ptr[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// Decode-side controller: resolves JMP/CALL/RET/JZ redirects towards fetch,
// detects load-use hazards, and issues one registered instruction per cycle.
module fetch_control
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int INS_W     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INS_W-1:0]  ins,
    input  logic [ADDR_W-1:0] current_address,
    input  logic              zero_flag,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic [INS_W-1:0]  ins_ex,
    output logic [ADDR_W-1:0] pc_ex,
    output logic              ras_err
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_d;
    logic              ld_valid;
    logic [4:0]        ld_rt;
    logic              hazard;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;

    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [ADDR_W-1:0] imm;

    assign op  = get_op(ins);
    assign rs  = get_rs(ins);
    assign rt  = get_rt(ins);
    assign imm = ADDR_W'(get_imm(ins));

    // The re-presented instruction in STALL is never checked again, which
    // bounds every load-use dependency to a single bubble.
    assign hazard = (state == RUN) && ld_valid && (ld_rt != 5'd0) &&
                    ((rs == ld_rt) || (rt == ld_rt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = RUN;
        if (state == RUN && hazard) begin
            state_next = STALL;
        end
    end

    always_comb begin
        pc_mux_sel = 1'b0;
        jmp_loc    = '0;
        stall      = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (!reset) begin
            if (hazard) begin
                stall = 1'b1;
            end else begin
                case (op)
                    OP_JMP: begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = imm;
                    end
                    OP_CALL: begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = imm;
                        ras_push   = 1'b1;
                    end
                    OP_RET: begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = ras_top;
                        ras_pop    = 1'b1;
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_mux_sel = 1'b1;
                            jmp_loc    = imm;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign stall_pm = stall;

    // pc_d holds during a bubble so the re-presented instruction keeps its own address
    always_ff @(posedge clk) begin
        if (reset) begin
            ins_ex   <= NOP;
            pc_ex    <= '0;
            pc_d     <= '0;
            ld_valid <= 1'b0;
            ld_rt    <= 5'd0;
        end else if (hazard) begin
            ins_ex   <= NOP;
            pc_ex    <= '0;
            ld_valid <= 1'b0;
        end else begin
            ins_ex   <= ins;
            pc_ex    <= pc_d;
            pc_d     <= current_address;
            ld_valid <= (op == OP_LD);
            ld_rt    <= rt;
        end
    end

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (current_address),
        .top   (ras_top),
        .err   (ras_err)
    );

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: directed scenarios then random traffic,
// checked against a queue-based behavioural model of decode, RAS and hazards.
module tb_fetch_control;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [15:0] current_address;
    logic        zero_flag;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        stall;
    logic        stall_pm;
    logic [31:0] ins_ex;
    logic [15:0] pc_ex;
    logic        ras_err;

    fetch_control #(
        .ADDR_W    (16),
        .INS_W     (32),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .current_address (current_address),
        .zero_flag       (zero_flag),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .stall           (stall),
        .stall_pm        (stall_pm),
        .ins_ex          (ins_ex),
        .pc_ex           (pc_ex),
        .ras_err         (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [15:0] pc;
        logic        err;
    } issue_t;

    issue_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: plain queue for the stack, flags for the rest
    logic [15:0] ras_q[$];
    bit          m_err;
    bit          m_ld;
    logic [4:0]  m_ld_rt;
    bit          m_in_stall;
    logic [15:0] m_prev_addr;
    bit          last_hazard;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0] op;
        int         kind;
        kind = $urandom_range(0, 9);
        case (kind)
            0:       op = OP_JMP;
            1:       op = OP_CALL;
            2:       op = OP_RET;
            3:       op = OP_JZ;
            4, 5:    op = OP_LD;
            default: begin
                op = 6'($urandom_range(6, 63));
                if (op == OP_LD) op = 6'h20;
            end
        endcase
        return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One decode cycle: drive inputs, advance the model, check combinational outputs
    task automatic cycle(input logic r, input logic [31:0] i, input logic [15:0] a, input logic z);
        logic        e_sel;
        logic        e_stall;
        logic [15:0] e_loc;
        issue_t      e;
        @(negedge clk);
        reset = r;
        ins = i;
        current_address = a;
        zero_flag = z;
        #1;
        e_sel = 1'b0;
        e_stall = 1'b0;
        e_loc = 16'h0;
        last_hazard = 1'b0;
        if (r) begin
            e = '0;
            ras_q.delete();
            m_err = 1'b0;
            m_ld = 1'b0;
            m_ld_rt = 5'd0;
            m_in_stall = 1'b0;
            m_prev_addr = 16'h0;
        end else if (!m_in_stall && m_ld && m_ld_rt != 5'd0 &&
                     (i[25:21] == m_ld_rt || i[20:16] == m_ld_rt)) begin
            e_stall = 1'b1;
            last_hazard = 1'b1;
            m_in_stall = 1'b1;
            m_ld = 1'b0;
            e = '{ins: 32'h0, pc: 16'h0, err: m_err};
        end else begin
            case (i[31:26])
                OP_JMP: begin
                    e_sel = 1'b1;
                    e_loc = i[15:0];
                end
                OP_CALL: begin
                    e_sel = 1'b1;
                    e_loc = i[15:0];
                    if (ras_q.size() >= DEPTH) m_err = 1'b1;
                    else ras_q.push_back(a);
                end
                OP_RET: begin
                    e_sel = 1'b1;
                    if (ras_q.size() == 0) begin
                        e_loc = 16'h0;
                        m_err = 1'b1;
                    end else begin
                        e_loc = ras_q.pop_back();
                    end
                end
                OP_JZ: begin
                    if (z) begin
                        e_sel = 1'b1;
                        e_loc = i[15:0];
                    end
                end
                default: begin
                end
            endcase
            e = '{ins: i, pc: m_prev_addr, err: m_err};
            m_ld = (i[31:26] == OP_LD);
            m_ld_rt = i[20:16];
            m_in_stall = 1'b0;
            m_prev_addr = a;
        end
        checks++;
        if (pc_mux_sel !== e_sel || jmp_loc !== e_loc || stall !== e_stall || stall_pm !== e_stall) begin
            errors++;
            $display("[TB] FAIL comb (ins=%h): sel/loc/stall/stall_pm got %b/%h/%b/%b, expected %b/%h/%b/%b",
                     i, pc_mux_sel, jmp_loc, stall, stall_pm, e_sel, e_loc, e_stall, e_stall);
        end
        exp_q.push_back(e);
    endtask

    // Fetch behaviour: a stalled instruction is re-presented at the held address
    task automatic issue(input logic [31:0] i, input logic [15:0] a, input logic z);
        cycle(1'b0, i, a, z);
        if (last_hazard) cycle(1'b0, i, a, z);
    endtask

    // Monitor: every clock edge produces one issued instruction to compare
    initial begin
        issue_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ins_ex !== e.ins || pc_ex !== e.pc || ras_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL issue: ins_ex/pc_ex/ras_err got %h/%h/%b, expected %h/%h/%b",
                             ins_ex, pc_ex, ras_err, e.ins, e.pc, e.err);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ins = 32'h0;
        current_address = 16'h0;
        zero_flag = 1'b0;

        for (int k = 0; k < 3; k++) cycle(1'b1, rand_ins(), 16'($urandom), 1'b1);

        issue(mk(OP_JMP, 5'd0, 5'd0, 16'h0040), 16'h0001, 1'b0);
        check_val("jmp_redirect", {15'h0, pc_mux_sel, jmp_loc}, {15'h0, 1'b1, 16'h0040});

        issue(mk(OP_LD, 5'd1, 5'd5, 16'h0004), 16'h0041, 1'b0);
        cycle(1'b0, mk(6'h00, 5'd5, 5'd1, 16'h0), 16'h0042, 1'b0);
        check_val("loaduse_stall", {30'h0, stall, pc_mux_sel}, {30'h0, 1'b1, 1'b0});
        cycle(1'b0, mk(6'h00, 5'd5, 5'd1, 16'h0), 16'h0042, 1'b0);
        check_val("loaduse_release", {31'h0, stall}, 32'h0);

        issue(mk(OP_LD, 5'd1, 5'd0, 16'h0), 16'h0043, 1'b0);
        issue(mk(6'h00, 5'd0, 5'd2, 16'h0), 16'h0044, 1'b0);
        issue(mk(OP_LD, 5'd1, 5'd5, 16'h0), 16'h0045, 1'b0);
        issue(mk(6'h00, 5'd6, 5'd7, 16'h0), 16'h0046, 1'b0);

        issue(mk(OP_CALL, 5'd0, 5'd0, 16'h0100), 16'h0011, 1'b0);
        issue(mk(OP_RET, 5'd0, 5'd0, 16'h0), 16'h0101, 1'b0);
        check_val("ret_target", {16'h0, jmp_loc}, 32'h0011);

        for (int k = 0; k < 5; k++)
            issue(mk(OP_CALL, 5'd0, 5'd0, 16'h0200 + 16'(k)), 16'h0021 + 16'(k), 1'b0);
        issue(mk(6'h08, 5'd9, 5'd9, 16'h0), 16'h0300, 1'b0);
        check_val("ras_overflow", {31'h0, ras_err}, 32'h1);
        for (int k = 0; k < 5; k++) issue(mk(OP_RET, 5'd0, 5'd0, 16'h0), 16'h0400 + 16'(k), 1'b0);
        issue(mk(6'h08, 5'd9, 5'd9, 16'h0), 16'h0500, 1'b0);
        check_val("ras_err_sticky", {31'h0, ras_err}, 32'h1);

        issue(mk(OP_JZ, 5'd0, 5'd0, 16'h0020), 16'h0600, 1'b0);
        issue(mk(OP_JZ, 5'd0, 5'd0, 16'h0020), 16'h0601, 1'b1);

        issue(mk(OP_LD, 5'd1, 5'd5, 16'h0), 16'h0700, 1'b0);
        cycle(1'b0, mk(6'h00, 5'd5, 5'd1, 16'h0), 16'h0701, 1'b0);
        cycle(1'b1, mk(6'h00, 5'd5, 5'd1, 16'h0), 16'h0701, 1'b0);
        issue(mk(6'h00, 5'd5, 5'd1, 16'h0), 16'h0702, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0)
                cycle(1'b1, rand_ins(), 16'($urandom), 1'($urandom_range(0, 1)));
            else
                issue(rand_ins(), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("scoreboard_drain", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
